dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAITST,
    RESP
  } state_e;

  // Byte-enable patterns the requester may issue: single bytes, aligned halves, full word.
  function automatic logic beLegal(input logic [WORD_BYTES-1:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-lane synchronous write and combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**IDX_W];

  // Write only the enabled lanes; disabled lanes keep their old bytes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read is combinational so the word can be registered on the same edge that enters RESP.
  always_comb begin
    rdata = mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: one request at a time, programmable wait states,
// single-cycle response pulse, illegal byte-enable detection.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWe,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [3:0]        reqBe,
  input  logic [31:0]       reqWData,
  output logic              rspValid,
  output logic [31:0]       rspRData,
  output logic              rspErr
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] WaitLoad = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;

  logic             accept;
  logic             enter_resp;
  logic             cur_we;
  logic             cur_legal;
  logic [IDX_W-1:0] cur_idx;
  logic [3:0]       cur_be;
  logic [31:0]      cur_wdata;
  logic             arr_we;
  logic [31:0]      arr_rdata;

  // Byte offset within the word is irrelevant to a word-wide responder.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^reqAddr[1:0];

  // Ready only in IDLE and never during a reset cycle.
  always_comb begin
    reqReady = rstn && (state_q == IDLE);
  end

  // Select the live request (WAIT=0 commits on the acceptance edge) or the latched one.
  always_comb begin
    accept     = reqValid && reqReady;
    cur_we     = we_q;
    cur_idx    = idx_q;
    cur_be     = be_q;
    cur_wdata  = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = reqWe;
      cur_idx   = reqAddr[ADDR_W-1:2];
      cur_be    = reqBe;
      cur_wdata = reqWData;
    end
    cur_legal  = beLegal(cur_be);
    enter_resp = rstn && (((state_q == IDLE) && accept && (WAIT == 0)) ||
                          ((state_q == WAITST) && (cnt_q == '0)));
    arr_we     = enter_resp && cur_we && cur_legal;
  end

  dmem_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (cur_be),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // Control FSM, request latch and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rspValid <= 1'b0;
      rspRData <= '0;
      rspErr   <= 1'b0;
    end else begin
      // Response fields are only meaningful during the pulse; clear them otherwise.
      rspValid <= 1'b0;
      rspRData <= '0;
      rspErr   <= 1'b0;
      if (enter_resp) begin
        rspValid <= 1'b1;
        rspErr   <= !cur_legal;
        rspRData <= (cur_legal && !cur_we) ? arr_rdata : '0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= reqWe;
            idx_q   <= reqAddr[ADDR_W-1:2];
            be_q    <= reqBe;
            wdata_q <= reqWData;
            if (WAIT == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAITST;
              cnt_q   <= WaitLoad;
            end
          end
        end
        WAITST: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT = 2, 0, 3) driven by directed and
// randomized requests, checked against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned AW = 12;
  localparam int unsigned NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn      [NI];
  logic          req_valid [NI];
  logic          req_ready [NI];
  logic          req_we    [NI];
  logic [AW-1:0] req_addr  [NI];
  logic [3:0]    req_be    [NI];
  logic [31:0]   req_wdata [NI];
  logic          rsp_valid [NI];
  logic [31:0]   rsp_rdata [NI];
  logic          rsp_err   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    dmem_responder #(
      .ADDR_W (AW),
      .WAIT   (W)
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn[g]),
      .reqValid (req_valid[g]),
      .reqReady (req_ready[g]),
      .reqWe    (req_we[g]),
      .reqAddr  (req_addr[g]),
      .reqBe    (req_be[g]),
      .reqWData (req_wdata[g]),
      .rspValid (rsp_valid[g]),
      .rspRData (rsp_rdata[g]),
      .rspErr   (rsp_err[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory: one word array per instance.
  logic [31:0] mem_m [NI][1024];
  logic [3:0]  legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned wait_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic logic be_ok(input logic [3:0] be);
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  task automatic check(input string tag, input int i, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s (u%0d): observed %h, expected %h", tag, i, obs, exp);
    end
  endtask

  // Expected response of one request, and the model memory update it causes.
  task automatic model(input int i, input logic we, input logic [AW-1:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       output logic [31:0] erd, output logic eerr);
    int unsigned w;
    w    = int'(addr) / 4;
    eerr = !be_ok(be);
    erd  = (eerr || we) ? 32'h0 : mem_m[i][w];
    if (we && !eerr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[i][w][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  // One complete transaction; called and returns at a falling edge.
  task automatic do_req(input int i, input logic we, input logic [AW-1:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic        eerr;
    int          cyc;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_be[i]    = be;
    req_wdata[i] = wd;
    cyc = 0;
    while (req_ready[i] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (req_ready[i] !== 1'b1) begin
      check("ready_timeout", i, 32'(req_ready[i]), 32'h1);
      req_valid[i] = 1'b0;
      rd = '0;
      er = 1'b0;
      return;
    end
    model(i, we, addr, be, wd, erd, eerr);
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    cyc = 1;
    while (rsp_valid[i] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", i, 32'(cyc), 32'(wait_of(i) + 1));
    check("ready_busy", i, 32'(req_ready[i]), 32'h0);
    check("rdata", i, rsp_rdata[i], erd);
    check("err", i, 32'(rsp_err[i]), 32'(eerr));
    rd = rsp_rdata[i];
    er = rsp_err[i];
    @(negedge clk);
    check("rsp_pulse", i, 32'(rsp_valid[i]), 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rd [4];
    logic        exp_er [4];
    logic        b_we   [4];
    logic [3:0]  b_be   [4];
    logic [31:0] b_wd   [4];
    logic [AW-1:0] bases [4];

    for (int i = 0; i < NI; i++) begin
      rstn[i]      = 1'b0;
      req_valid[i] = 1'b1;
      req_we[i]    = 1'b1;
      req_addr[i]  = '0;
      req_be[i]    = 4'hF;
      req_wdata[i] = 32'hFFFF_FFFF;
    end

    // Reset held three cycles with requests pending.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check("rst_valid", i, 32'(rsp_valid[i]), 32'h0);
        check("rst_rdata", i, rsp_rdata[i], 32'h0);
        check("rst_err", i, 32'(rsp_err[i]), 32'h0);
        check("rst_ready", i, 32'(req_ready[i]), 32'h0);
      end
    end
    for (int i = 0; i < NI; i++) begin
      rstn[i]      = 1'b1;
      req_valid[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < NI; i++) check("ready_after_rst", i, 32'(req_ready[i]), 32'h1);
    @(negedge clk);

    // Word store/load, WAIT=2.
    do_req(0, 1'b1, 12'h010, 4'b1111, 32'hDEADBEEF, rd, er);
    do_req(0, 1'b0, 12'h010, 4'b1111, 32'h0, rd, er);
    check("ld_word", 0, rd, 32'hDEADBEEF);
    check("ld_word_err", 0, 32'(er), 32'h0);

    // Partial-lane stores.
    do_req(0, 1'b1, 12'h020, 4'b1111, 32'h11223344, rd, er);
    do_req(0, 1'b1, 12'h020, 4'b0100, 32'h00AA0000, rd, er);
    do_req(0, 1'b0, 12'h020, 4'b1111, 32'h0, rd, er);
    check("ld_lane2", 0, rd, 32'h11AA3344);
    do_req(0, 1'b1, 12'h020, 4'b0011, 32'h00005566, rd, er);
    do_req(0, 1'b0, 12'h020, 4'b1111, 32'h0, rd, er);
    check("ld_half", 0, rd, 32'h11AA5566);

    // Illegal enables: store suppressed, load returns zero.
    do_req(0, 1'b1, 12'h020, 4'b0101, 32'hFFFFFFFF, rd, er);
    check("ill_st_err", 0, 32'(er), 32'h1);
    check("ill_st_rd", 0, rd, 32'h0);
    do_req(0, 1'b0, 12'h020, 4'b0000, 32'h0, rd, er);
    check("ill_ld_err", 0, 32'(er), 32'h1);
    check("ill_ld_rd", 0, rd, 32'h0);
    do_req(0, 1'b0, 12'h020, 4'b1111, 32'h0, rd, er);
    check("ld_unchanged", 0, rd, 32'h11AA5566);

    // Back-to-back with WAIT=0 and reqValid held high.
    b_we[0] = 1'b1; b_be[0] = 4'b1111; b_wd[0] = $urandom;
    b_we[1] = 1'b0; b_be[1] = 4'b1111; b_wd[1] = 32'h0;
    b_we[2] = 1'b1; b_be[2] = 4'b1000; b_wd[2] = $urandom;
    b_we[3] = 1'b0; b_be[3] = 4'b0010; b_wd[3] = 32'h0;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        check("b2b_ready_hi", 1, 32'(req_ready[1]), 32'h1);
        check("b2b_novalid", 1, 32'(rsp_valid[1]), 32'h0);
        req_we[1]    = b_we[k/2];
        req_addr[1]  = 12'h100;
        req_be[1]    = b_be[k/2];
        req_wdata[1] = b_wd[k/2];
        model(1, b_we[k/2], 12'h100, b_be[k/2], b_wd[k/2], exp_rd[k/2], exp_er[k/2]);
      end else begin
        check("b2b_ready_lo", 1, 32'(req_ready[1]), 32'h0);
        check("b2b_valid", 1, 32'(rsp_valid[1]), 32'h1);
        check("b2b_rdata", 1, rsp_rdata[1], exp_rd[k/2]);
        check("b2b_err", 1, 32'(rsp_err[1]), 32'(exp_er[k/2]));
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    @(negedge clk);

    // Randomized traffic on every instance over a few pre-initialised words.
    bases[0] = 12'h040; bases[1] = 12'h044; bases[2] = 12'h080; bases[3] = 12'hFFC;
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 4; a++) do_req(i, 1'b1, bases[a], 4'hF, $urandom, rd, er);
      for (int t = 0; t < 16; t++) begin
        logic [3:0]    be;
        logic [AW-1:0] addr;
        addr = bases[$urandom_range(0, 3)] | AW'($urandom_range(0, 3));
        be   = ($urandom_range(0, 1) == 1) ? legal_list[$urandom_range(0, 6)]
                                           : 4'($urandom_range(0, 15));
        do_req(i, 1'($urandom_range(0, 1)), addr, be, $urandom, rd, er);
      end
    end

    // Reset during the second wait state of a store on the WAIT=3 instance.
    do_req(2, 1'b1, 12'h030, 4'b1111, 32'h0, rd, er);
    check("mid_pre_ready", 2, 32'(req_ready[2]), 32'h1);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 12'h030;
    req_be[2]    = 4'b1111;
    req_wdata[2] = 32'hCAFE0001 | $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rstn[2] = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 2, 32'(rsp_valid[2]), 32'h0);
    rstn[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mid_no_rsp", 2, 32'(rsp_valid[2]), 32'h0);
    end
    do_req(2, 1'b0, 12'h030, 4'b1111, 32'h0, rd, er);
    check("mid_discard", 2, rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
